// File: rtl/apb_reg_bank.sv
// APB slave register bank with programmable wait states and decode-error response.
// Optional per-byte write strobes are enabled by defining APB_REG_BANK_PSTRB_EN.
module apb_reg_bank #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    NUM_REGS    = 4,
    parameter int                    WAIT_STATES = 0,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                           PCLK,
    input  logic                           PRESET,
    input  logic                           PSEL,
    input  logic                           PENABLE,
    input  logic                           PWRITE,
    input  logic [ADDR_WIDTH-1:0]          PADDR,
    input  logic [DATA_WIDTH-1:0]          PWDATA,
`ifdef APB_REG_BANK_PSTRB_EN
    input  logic [DATA_WIDTH/8-1:0]        PSTRB,
`endif
    output logic [DATA_WIDTH-1:0]          PRDATA,
    output logic                           PREADY,
    output logic                           PSLVERR,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

    localparam int         NUM_BYTES = DATA_WIDTH / 8;
    localparam int         IDX_W     = ADDR_WIDTH - 2;
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_WAIT   = 1'b1;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    logic [0:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx;
    logic [NUM_REGS-1:0]   hit;
    logic                  addr_err;
    logic                  commit;
    logic [NUM_BYTES-1:0]  byte_en;
    logic [DATA_WIDTH-1:0] rd_mux;

    assign idx      = PADDR[ADDR_WIDTH-1:2];
    // No register hit covers both idx >= NUM_REGS and any unmapped index.
    assign addr_err = (PADDR[1:0] != 2'b00) || (hit == '0);
    assign PREADY   = (state_q == ST_WAIT) && (cnt_q == 4'd0) && PSEL && PENABLE;
    assign PSLVERR  = PREADY && addr_err;
    assign commit   = PREADY && PWRITE && !addr_err;

`ifdef APB_REG_BANK_PSTRB_EN
    assign byte_en = PSTRB;
`else
    assign byte_en = '1;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (PSEL && !PENABLE) begin
                    state_d = ST_WAIT;
                    cnt_d   = WAIT_INIT;
                end
            end
            ST_WAIT: begin
                if (!PSEL) begin
                    state_d = ST_IDLE;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (PENABLE) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    genvar gi, bi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : gen_reg
            logic [DATA_WIDTH-1:0] reg_q, reg_d;

            assign hit[gi] = (idx == IDX_W'(gi));

            for (bi = 0; bi < NUM_BYTES; bi++) begin : gen_byte
                assign reg_d[bi*8 +: 8] = (commit && hit[gi] && byte_en[bi]) ?
                                          PWDATA[bi*8 +: 8] : reg_q[bi*8 +: 8];
            end

            always_ff @(posedge PCLK) begin
                if (PRESET) begin
                    reg_q <= RESET_VALUE;
                end else begin
                    reg_q <= reg_d;
                end
            end

            assign regs_o[gi*DATA_WIDTH +: DATA_WIDTH] = reg_q;
        end
    endgenerate

    // One-hot OR mux; hit has at most one bit set.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (hit[i]) begin
                rd_mux = rd_mux | regs_o[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign PRDATA = (PREADY && !PWRITE && !addr_err) ? rd_mux : '0;

endmodule

// File: tb/tb_apb_reg_bank.sv
// Self-checking bench for apb_reg_bank: a zero-wait instance and a 3-wait-state,
// 3-register instance with a non-zero reset value share one APB bus, steered by dsel.
module tb_apb_reg_bank;

`ifdef APB_REG_BANK_PSTRB_EN
    localparam bit STRB_EN = 1'b1;
`else
    localparam bit STRB_EN = 1'b0;
`endif
    localparam logic [31:0] RV3    = 32'h5A5A_1234;
    localparam logic [31:0] EXP_R1 = STRB_EN ? 32'h11BB_33DD : 32'hAABB_CCDD;
    localparam logic [31:0] EXP_R2 = STRB_EN ? 32'h0000_0000 : 32'h0102_0304;

    logic        clk, preset, psel, penable, pwrite, dsel;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        psel0, psel3;
    logic [31:0] prdata0, prdata3;
    logic        pready0, pready3, pslverr0, pslverr3;
    logic [127:0] regs0;
    logic [95:0]  regs3;

    assign psel0 = psel & ~dsel;
    assign psel3 = psel & dsel;

    apb_reg_bank #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_REGS(4), .WAIT_STATES(0),
                   .RESET_VALUE(32'h0)) u_dut0 (
        .PCLK(clk), .PRESET(preset), .PSEL(psel0), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata),
`ifdef APB_REG_BANK_PSTRB_EN
        .PSTRB(pstrb),
`endif
        .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0), .regs_o(regs0));

    apb_reg_bank #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_REGS(3), .WAIT_STATES(3),
                   .RESET_VALUE(RV3)) u_dut3 (
        .PCLK(clk), .PRESET(preset), .PSEL(psel3), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata),
`ifdef APB_REG_BANK_PSTRB_EN
        .PSTRB(pstrb),
`endif
        .PRDATA(prdata3), .PREADY(pready3), .PSLVERR(pslverr3), .regs_o(regs3));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit          d;
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        bit          err;
        int          cyc;
        string       tag;
    } exp_t;

    vec_t        vecs[20];
    exp_t        sb[$];
    logic [31:0] m0[4];
    logic [31:0] m3[3];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] st);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++)
            if (!STRB_EN || st[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    task automatic chk_regs(input string tag);
        chk({tag, " regs0"}, regs0, {m0[3], m0[2], m0[1], m0[0]});
        chk({tag, " regs3"}, {32'h0, regs3}, {32'h0, m3[2], m3[1], m3[0]});
    endtask

    // Drives one transfer; the scoreboard entry is popped and compared on PREADY.
    task automatic xfer(input bit d, input bit wr, input logic [7:0] a,
                        input logic [31:0] wd, input logic [3:0] st);
        exp_t e;
        int   cyc;
        bit   done;
        dsel = d; psel = 1'b1; penable = 1'b0; pwrite = wr;
        paddr = a; pwdata = wd; pstrb = st;
        @(posedge clk); #1;
        penable = 1'b1;
        cyc  = 1;
        done = 1'b0;
        e    = sb.pop_front();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cyc++;
            if (d ? pready3 : pready0) begin
                chk({e.tag, " prdata"}, {96'h0, d ? prdata3 : prdata0}, {96'h0, e.rdata});
                chk({e.tag, " pslverr"}, {127'h0, d ? pslverr3 : pslverr0}, {127'h0, e.err});
                chk({e.tag, " cycles"}, 128'(cyc), 128'(e.cyc));
                done = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            errors++;
            $display("FAIL %s timeout: got no PREADY expected PREADY within 40 cycles", e.tag);
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic push_exp(input logic [31:0] rd, input bit err, input bit d, input string tag);
        exp_t e;
        e.rdata = rd; e.err = err; e.cyc = d ? 5 : 2; e.tag = tag;
        sb.push_back(e);
    endtask

    initial begin
        vecs[0]  = '{0, 1, 8'h04, 32'hDEAD_BEEF, 4'hF, 32'h0,         0};
        vecs[1]  = '{0, 0, 8'h04, 32'h0,         4'hF, 32'hDEAD_BEEF, 0};
        vecs[2]  = '{0, 0, 8'h00, 32'h0,         4'hF, 32'h0,         0};
        vecs[3]  = '{0, 1, 8'h10, 32'h1234_5678, 4'hF, 32'h0,         1};
        vecs[4]  = '{0, 1, 8'h02, 32'hCAFE_F00D, 4'hF, 32'h0,         1};
        vecs[5]  = '{0, 0, 8'h10, 32'h0,         4'hF, 32'h0,         1};
        vecs[6]  = '{0, 1, 8'h0C, 32'h0000_FFFF, 4'hF, 32'h0,         0};
        vecs[7]  = '{0, 0, 8'h0C, 32'h0,         4'hF, 32'h0000_FFFF, 0};
        vecs[8]  = '{0, 1, 8'h04, 32'h1122_3344, 4'hF, 32'h0,         0};
        vecs[9]  = '{0, 1, 8'h04, 32'hAABB_CCDD, 4'h5, 32'h0,         0};
        vecs[10] = '{0, 0, 8'h04, 32'h0,         4'h0, EXP_R1,        0};
        vecs[11] = '{0, 1, 8'h08, 32'h0102_0304, 4'h0, 32'h0,         0};
        vecs[12] = '{0, 0, 8'h08, 32'h0,         4'hF, EXP_R2,        0};
        vecs[13] = '{1, 0, 8'h00, 32'h0,         4'hF, RV3,           0};
        vecs[14] = '{1, 1, 8'h08, 32'h0BAD_CAFE, 4'hF, 32'h0,         0};
        vecs[15] = '{1, 0, 8'h08, 32'h0,         4'hF, 32'h0BAD_CAFE, 0};
        vecs[16] = '{1, 1, 8'h0C, 32'h1111_1111, 4'hF, 32'h0,         1};
        vecs[17] = '{1, 0, 8'h0C, 32'h0,         4'hF, 32'h0,         1};
        vecs[18] = '{1, 0, 8'h09, 32'h0,         4'hF, 32'h0,         1};
        vecs[19] = '{1, 0, 8'hFC, 32'h0,         4'hF, 32'h0,         1};

        for (int i = 0; i < 4; i++) m0[i] = 32'h0;
        for (int i = 0; i < 3; i++) m3[i] = RV3;

        preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; dsel = 1'b0;
        paddr = 8'h0; pwdata = 32'h0; pstrb = 4'hF;
        repeat (2) @(posedge clk);
        #1 preset = 1'b0;
        @(negedge clk);
        chk("reset pready", {126'h0, pready0, pready3}, 128'h0);
        chk("reset pslverr", {126'h0, pslverr0, pslverr3}, 128'h0);
        chk("reset prdata", {64'h0, prdata0, prdata3}, 128'h0);
        chk_regs("reset");

        // Protocol violation: PENABLE without setup must not start a transfer.
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h00; pwdata = 32'hFFFF_FFFF;
        repeat (3) begin
            @(negedge clk);
            chk("penable-in-idle pready", {127'h0, pready0}, 128'h0);
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        chk_regs("penable-in-idle");

        for (int i = 0; i < 20; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            push_exp(vecs[i].exp_rd, vecs[i].exp_err, vecs[i].d, tag);
            xfer(vecs[i].d, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb);
            if (vecs[i].wr && !vecs[i].exp_err) begin
                if (vecs[i].d)
                    m3[vecs[i].addr[7:2]] = merge(m3[vecs[i].addr[7:2]], vecs[i].wdata, vecs[i].strb);
                else
                    m0[vecs[i].addr[7:2]] = merge(m0[vecs[i].addr[7:2]], vecs[i].wdata, vecs[i].strb);
            end
            chk_regs(tag);
        end

        // Abort: PSEL dropped in the second wait cycle of a write on the wait-state instance.
        dsel = 1'b1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 8'h04; pwdata = 32'h7777_7777; pstrb = 4'hF;
        @(posedge clk); #1 penable = 1'b1;
        @(negedge clk);
        chk("abort wait1 pready", {127'h0, pready3}, 128'h0);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        chk("abort pready", {127'h0, pready3}, 128'h0);
        @(posedge clk); #1;
        chk_regs("abort");
        push_exp(RV3, 1'b0, 1'b1, "after-abort read");
        xfer(1'b1, 1'b0, 8'h04, 32'h0, 4'hF);

        // Reset on the commit edge of a zero-wait write: the write must be lost.
        dsel = 1'b0; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 8'h08; pwdata = 32'hAAAA_5555; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1; preset = 1'b1;
        @(posedge clk); #1;
        preset = 1'b0; psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) m0[i] = 32'h0;
        for (int i = 0; i < 3; i++) m3[i] = RV3;
        chk("mid-reset pready", {126'h0, pready0, pready3}, 128'h0);
        chk_regs("mid-reset");

        push_exp(32'h0, 1'b0, 1'b0, "post-reset dut0 read");
        xfer(1'b0, 1'b0, 8'h08, 32'h0, 4'hF);
        push_exp(RV3, 1'b0, 1'b1, "post-reset dut3 read");
        xfer(1'b1, 1'b0, 8'h08, 32'h0, 4'hF);
        chk_regs("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
